// File: rtl/multi_string_led_controller.sv
// Wishbone-mapped multi-channel serial LED string driver (WS281x-style GRB).
// Each channel has its own pixel RAM slice, bit-timing FSM, continuous mode and IRQ.
module multi_string_led_controller #(
  parameter int NCH   = 2,
  parameter int ASIZE = 4,
  parameter int TBIT  = 50,
  parameter int T0H   = 16,
  parameter int T1H   = 32,
  parameter int TRST  = 2400
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic [31:0]    wbs_dat_o,
  output logic           wbs_ack_o,
  output logic [NCH-1:0] led_o,
  output logic           irq
);
  localparam int NPIX = 1 << ASIZE;
  localparam int MD   = NCH * NPIX;
  localparam int MW   = (MD > 1) ? $clog2(MD) : 1;
  localparam int MDP  = 1 << MW;
  localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = ASIZE + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_HIGH, S_LOW, S_GAP
  } st_t;

  logic [23:0]    r_mem [0:MDP-1];
  logic [LW-1:0]  r_len_cfg [NCH];
  logic [NCH-1:0] r_cont;
  logic [NCH-1:0] r_inv;
  logic [NCH-1:0] r_irq_en;
  logic [NCH-1:0] r_done;
  logic           r_ack;
  logic [31:0]    r_dat;

  logic           w_acc;
  logic           w_wr;
  logic           w_low;
  logic [9:0]     w_word;
  logic           w_pix_hit;
  logic [MW-1:0]  w_pix_idx;
  logic [NCH-1:0] w_cfg_sel;
  logic [31:0]    w_rdata;
  logic [NCH-1:0] w_start;
  logic [NCH-1:0] w_w1c;
  logic [NCH-1:0] w_busy;
  logic [NCH-1:0] w_done_set;
  logic [NCH-1:0] w_line;
  logic           w_unused;

  assign w_unused  = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};
  assign w_acc     = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_wr      = w_acc && wbs_we_i;
  assign w_low     = (wbs_adr_i[31:12] == '0);
  assign w_word    = wbs_adr_i[11:2];
  assign w_pix_hit = w_low && w_word[9] &&
                     (32'(w_word[8:0]) < MD);
  assign w_pix_idx = w_word[MW-1:0];

  assign w_start = (w_wr && w_low && w_word == 10'd0) ?
                   wbs_dat_i[NCH-1:0] : '0;
  assign w_w1c   = (w_wr && w_low && w_word == 10'd1) ?
                   wbs_dat_i[8 +: NCH] : '0;

  always_comb begin
    w_cfg_sel = '0;
    for (int c = 0; c < NCH; c++)
      w_cfg_sel[c] = w_low && (w_word == 10'(4 + c));
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_pix_hit:
        w_rdata = {8'h00, r_mem[w_pix_idx]};
      w_low && w_word == 10'd1:
        w_rdata = {16'h0, 8'(r_done), 8'(w_busy)};
      w_low && w_word == 10'd2:
        w_rdata = 32'(r_irq_en);
      default: ;
    endcase
    for (int c = 0; c < NCH; c++)
      if (w_cfg_sel[c])
        w_rdata = {14'h0, r_inv[c], r_cont[c],
                   {(16-LW){1'b0}}, r_len_cfg[c]};
  end

  always_ff @(posedge clk)
    if (w_wr && w_pix_hit)
      r_mem[w_pix_idx] <= wbs_dat_i[23:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq_en <= '0;
      r_done   <= '0;
      r_cont   <= '0;
      r_inv    <= '0;
      for (int c = 0; c < NCH; c++)
        r_len_cfg[c] <= '0;
    end else begin
      r_ack  <= w_acc;
      r_dat  <= w_acc ? w_rdata : '0;
      // a channel finishing in the same cycle as a W1C keeps its done bit
      r_done <= (r_done & ~w_w1c) | w_done_set;
      if (w_wr && w_low && w_word == 10'd2)
        r_irq_en <= wbs_dat_i[NCH-1:0];
      for (int c = 0; c < NCH; c++)
        if (w_wr && w_cfg_sel[c]) begin
          r_len_cfg[c] <= wbs_dat_i[LW-1:0];
          r_cont[c]    <= wbs_dat_i[16];
          r_inv[c]     <= wbs_dat_i[17];
        end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    st_t           r_st, w_st;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [4:0]    r_bit, w_bit;
    logic [LW-1:0] r_pix, w_pix;
    logic [LW-1:0] r_len, w_len;
    logic [23:0]   r_sh, w_sh;
    logic          w_set;
    logic [LW-1:0] w_elen;
    logic [LW-1:0] w_pn;
    logic [CW-1:0] w_th;
    logic [MW-1:0] w_base;

    assign w_elen = (r_len_cfg[c] > LW'(NPIX)) ?
                    LW'(NPIX) : r_len_cfg[c];
    assign w_pn   = r_pix + LW'(1);
    assign w_th   = r_sh[23] ? CW'(T1H) : CW'(T0H);
    assign w_base = MW'(c * NPIX);

    always_comb begin
      w_st  = r_st;
      w_cnt = r_cnt + CW'(1);
      w_bit = r_bit;
      w_pix = r_pix;
      w_len = r_len;
      w_sh  = r_sh;
      w_set = 1'b0;
      unique case (r_st)
        S_IDLE: begin
          w_cnt = '0;
          if (w_start[c]) begin
            if (w_elen == '0) begin
              w_set = 1'b1;
            end else begin
              w_st  = S_HIGH;
              w_bit = '0;
              w_pix = '0;
              w_len = w_elen;
              w_sh  = r_mem[w_base];
            end
          end
        end
        S_HIGH:
          if (r_cnt == w_th - CW'(1))
            w_st = S_LOW;
        S_LOW:
          if (r_cnt == CW'(TBIT - 1)) begin
            w_cnt = '0;
            if (r_bit != 5'd23) begin
              w_st  = S_HIGH;
              w_bit = r_bit + 5'd1;
              w_sh  = {r_sh[22:0], 1'b0};
            end else if (w_pn < r_len) begin
              w_st  = S_HIGH;
              w_bit = '0;
              w_pix = w_pn;
              w_sh  = r_mem[w_base + MW'(w_pn)];
            end else begin
              w_st = S_GAP;
            end
          end
        S_GAP:
          if (r_cnt == CW'(TRST - 1)) begin
            w_set = 1'b1;
            w_cnt = '0;
            if (r_cont[c] && w_elen != '0) begin
              w_st  = S_HIGH;
              w_bit = '0;
              w_pix = '0;
              w_len = w_elen;
              w_sh  = r_mem[w_base];
            end else begin
              w_st = S_IDLE;
            end
          end
        default: w_st = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_st  <= S_IDLE;
        r_cnt <= '0;
        r_bit <= '0;
        r_pix <= '0;
        r_len <= '0;
        r_sh  <= '0;
      end else begin
        r_st  <= w_st;
        r_cnt <= w_cnt;
        r_bit <= w_bit;
        r_pix <= w_pix;
        r_len <= w_len;
        r_sh  <= w_sh;
      end
    end

    assign w_busy[c]     = (r_st != S_IDLE);
    assign w_line[c]     = (r_st == S_HIGH);
    assign w_done_set[c] = w_set;
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign led_o     = w_line ^ r_inv;
  assign irq       = |(r_done & r_irq_en);

endmodule

// File: tb/tb_multi_string_led_controller.sv
// Scoreboard bench for multi_string_led_controller: read data and LED
// pulse widths are queued by stimulus and checked by independent monitors.
module tb_multi_string_led_controller;
  localparam int TBIT = 10;
  localparam int T0H  = 3;
  localparam int T1H  = 7;
  localparam int TRST = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic [1:0]  led_o;
  logic        irq;

  multi_string_led_controller #(
    .NCH(2), .ASIZE(4), .TBIT(TBIT),
    .T0H(T0H), .T1H(T1H), .TRST(TRST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .led_o(led_o), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic [31:0] q_rd[$];
  string       q_nm[$];
  int          q_p0[$];
  int          q_p1[$];
  logic [1:0]  tb_inv = 2'b00;
  logic        cur_we = 1'b0;
  logic        prev_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] a,
                          input logic [31:0] d);
    int n;
    @(negedge clk);
    cur_we = we;
    wbs_we_i = we;
    wbs_adr_i = a;
    wbs_dat_i = d;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wbs_ack_o && n < 20);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    if (!wbs_ack_o) begin
      total++;
      bad++;
      $display("FAIL wb_ack adr=0x%0h: got no ack want ack", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wb_cycle(1'b1, a, d);
  endtask

  task automatic rd(input string nm, input logic [31:0] a,
                    input logic [31:0] exp);
    q_rd.push_back(exp);
    q_nm.push_back(nm);
    wb_cycle(1'b0, a, 32'h0);
  endtask

  task automatic push_frame(input int c, input logic [23:0] px);
    for (int b = 23; b >= 0; b--) begin
      if (c == 0) q_p0.push_back(px[b] ? T1H : T0H);
      else        q_p1.push_back(px[b] ? T1H : T0H);
    end
  endtask

  task automatic wait_irq(input string nm, input int t0,
                          input int exp);
    int n;
    n = 0;
    while (!irq && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(cnt - t0), 32'(exp));
  endtask

  task automatic pulse_end(input int c, input int w);
    int e;
    if ((c == 0 && q_p0.size() == 0) ||
        (c == 1 && q_p1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL ch%0d_pulse: got width %0d want no pulse", c, w);
    end else begin
      e = (c == 0) ? q_p0.pop_front() : q_p1.pop_front();
      chk($sformatf("ch%0d_high", c), 32'(w), 32'(e));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (wbs_ack_o) begin
      chk("ack_one_cycle", {31'h0, prev_ack}, 32'h0);
      if (!cur_we) begin
        if (q_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_extra: got 0x%0h want no read", wbs_dat_o);
        end else begin
          chk(q_nm.pop_front(), wbs_dat_o, q_rd.pop_front());
        end
      end
    end
    prev_ack = wbs_ack_o;
  end

  int hi [2];
  int lo [2];
  int lh [2];
  initial
    for (int c = 0; c < 2; c++) begin
      hi[c] = 0;
      lo[c] = 1000;
      lh[c] = 0;
    end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        hi[c] = 0;
        lo[c] = 1000;
      end else if ((led_o[c] ^ tb_inv[c]) == 1'b1) begin
        if (hi[c] == 0 && lo[c] < TRST)
          chk($sformatf("ch%0d_low", c), 32'(lo[c]),
              32'(TBIT - lh[c]));
        hi[c]++;
        lo[c] = 0;
      end else begin
        if (hi[c] != 0) begin
          pulse_end(c, hi[c]);
          lh[c] = hi[c];
          hi[c] = 0;
        end
        lo[c]++;
      end
    end
  end

  function automatic logic [23:0] pv(input int i);
    pv = 24'h800000 ^ 24'(i * 24'h050301);
  endfunction

  localparam logic [31:0] A_CTRL = 32'h000;
  localparam logic [31:0] A_STAT = 32'h004;
  localparam logic [31:0] A_IEN  = 32'h008;
  localparam logic [31:0] A_CFG0 = 32'h010;
  localparam logic [31:0] A_CFG1 = 32'h014;

  function automatic logic [31:0] pa(input int c, input int i);
    pa = 32'h800 + 32'(c * 64) + 32'(i * 4);
  endfunction

  int t0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led_o), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ack", 32'(wbs_ack_o), 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    rd("stat_rst", A_STAT, 32'h0);
    rd("cfg0_rst", A_CFG0, 32'h0);
    rd("ien_rst", A_IEN, 32'h0);

    wr(pa(0, 0), 32'hABFF0000);
    rd("pix_rb", pa(0, 0), 32'h00FF0000);
    wr(pa(1, 15), 32'h00C0FFEE);
    rd("pix_last", pa(1, 15), 32'h00C0FFEE);
    wr(pa(2, 0), 32'h00111111);
    rd("pix_oor", pa(2, 0), 32'h0);
    rd("pix_noalias", pa(0, 0), 32'h00FF0000);
    wr(32'h018, 32'h3001F);
    rd("cfg2_oor", 32'h018, 32'h0);
    rd("unmapped", 32'h00C, 32'h0);
    rd("ctrl_rd", A_CTRL, 32'h0);

    wr(A_CFG0, 32'h1);
    wr(A_IEN, 32'h1);
    push_frame(0, 24'hFF0000);
    wr(A_CTRL, 32'h1);
    t0 = cnt;
    wait_irq("frame1_time", t0, 24 * TBIT + TRST);
    rd("stat_done0", A_STAT, 32'h0100);
    chk("irq_set", 32'(irq), 32'h1);
    wr(A_STAT, 32'h0100);
    chk("irq_clr", 32'(irq), 32'h0);

    wr(A_CFG0, 32'h0);
    wr(A_CTRL, 32'h1);
    chk("len0_irq", 32'(irq), 32'h1);
    rd("len0_stat", A_STAT, 32'h0100);
    wr(A_STAT, 32'h0100);

    for (int i = 0; i < 16; i++) begin
      wr(pa(0, i), 32'(pv(i)));
      push_frame(0, pv(i));
    end
    wr(A_CFG0, 32'h1F);
    wr(A_CTRL, 32'h1);
    t0 = cnt;
    wait_irq("clamp_time", t0, 16 * 24 * TBIT + TRST);
    wr(A_STAT, 32'h0100);

    wr(pa(0, 0), 32'h00A5A5A5);
    wr(pa(0, 1), 32'h000F0F0F);
    wr(pa(1, 0), 32'h00123456);
    wr(A_CFG0, 32'h2);
    wr(A_CFG1, 32'h1);
    wr(A_IEN, 32'h3);
    push_frame(0, 24'hA5A5A5);
    push_frame(0, 24'h0F0F0F);
    push_frame(1, 24'h123456);
    wr(A_CTRL, 32'h3);
    t0 = cnt;
    repeat (100) @(posedge clk);
    wr(A_CTRL, 32'h1);
    wait_irq("dual_ch1_time", t0, 24 * TBIT + TRST);
    rd("dual_stat1", A_STAT, 32'h0201);
    wr(A_STAT, 32'h0200);
    wait_irq("dual_ch0_time", t0, 48 * TBIT + TRST);
    rd("dual_stat0", A_STAT, 32'h0100);
    wr(A_STAT, 32'h0100);

    wr(pa(1, 0), 32'h00800001);
    wr(A_IEN, 32'h2);
    wr(A_CFG1, 32'h30001);
    tb_inv[1] = 1'b1;
    chk("inv_idle", 32'(led_o), 32'h2);
    for (int f = 0; f < 3; f++) push_frame(1, 24'h800001);
    wr(A_CTRL, 32'h2);
    t0 = cnt;
    wait_irq("cont_f1", t0, 24 * TBIT + TRST);
    rd("cont_stat", A_STAT, 32'h0202);
    wr(A_STAT, 32'h0200);
    wait_irq("cont_f2", t0, 2 * (24 * TBIT + TRST));
    wr(A_STAT, 32'h0200);
    wr(A_CFG1, 32'h20001);
    wait_irq("cont_f3", t0, 3 * (24 * TBIT + TRST));
    repeat (300) @(posedge clk);
    rd("cont_end_stat", A_STAT, 32'h0200);
    #1;
    chk("inv_idle_end", 32'(led_o), 32'h2);
    wr(A_STAT, 32'h0200);

    wr(pa(0, 0), 32'h00FFFFFF);
    wr(A_CFG0, 32'h1);
    wr(A_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    tb_inv = 2'b00;
    #1;
    chk("midrst_led", 32'(led_o), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    rd("midrst_stat", A_STAT, 32'h0);
    rd("midrst_cfg0", A_CFG0, 32'h0);
    rd("midrst_ien", A_IEN, 32'h0);
    repeat (5) @(posedge clk);

    chk("q_p0_left", 32'(q_p0.size()), 32'h0);
    chk("q_p1_left", 32'(q_p1.size()), 32'h0);
    chk("q_rd_left", 32'(q_rd.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
